// File: rtl/usb_ls_tx.sv
// Low-speed USB serialiser: SYNC, NRZI, bit stuffing and EOP from a byte stream.
// Define USB_LS_TX_CRC16_EN to append a complemented CRC16 to multi-byte packets.
module usb_ls_tx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp_o,
  output logic       dm_o,
  output logic       oe_o,
  output logic       busy_o,
  output logic       underrun_o
);
  // state   | meaning
  // IDLE    | line released, waiting for a byte
  // SYNC    | sending 00000001
  // DATA    | sending packet bytes (and CRC when enabled), stuffed
  // EOP_SE0 | two bit times of SE0
  // EOP_J   | one bit time of J, then release the line
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_shift;
  logic [2:0]      r_pos;
  logic [2:0]      r_ones;
  logic [7:0]      r_hold;
  logic            r_hold_full;
  logic            r_hold_last;
  logic            r_last_seen;
  logic            r_cur_last;
  logic            r_se0_second;
  logic            r_dp;
  logic            r_dm;
  logic            r_oe;
  logic            r_busy;
  logic            r_underrun;
`ifdef USB_LS_TX_CRC16_EN
  logic [15:0]     r_crc;
  logic            r_pid;
  logic            r_crc_phase;
  logic            r_crc_hi;
  logic            w_crc_start;
  logic            w_crc_en;
  logic            w_crc_fb;
  logic [15:0]     w_crc_next;
`endif

  logic       w_accept;
  logic       w_bit_end;
  logic       w_stuff;
  logic       w_byte_end;
  logic [7:0] w_nb;
  logic       w_more;
  logic       w_from_hold;
  logic       w_underrun;
  logic       w_tx_bit;

  assign tx_ready   = !r_hold_full && !r_last_seen;
  assign w_accept   = tx_valid && tx_ready;
  assign w_bit_end  = (r_cnt == BIT_END);
  assign w_stuff    = (r_ones == 3'd6);
  assign w_byte_end = (r_pos == 3'd7);

  assign dp_o       = r_dp;
  assign dm_o       = r_dm;
  assign oe_o       = r_oe;
  assign busy_o     = r_busy;
  assign underrun_o = r_underrun;

  // Source of the next byte at a byte boundary, and whether the packet continues.
  always_comb begin
    w_nb        = r_hold;
    w_more      = r_hold_full;
    w_from_hold = 1'b1;
    w_underrun  = 1'b0;
`ifdef USB_LS_TX_CRC16_EN
    w_crc_start = 1'b0;
`endif
    if (r_state == DATA) begin
`ifdef USB_LS_TX_CRC16_EN
      if (r_crc_phase) begin
        w_from_hold = 1'b0;
        w_nb        = ~r_crc[15:8];
        w_more      = !r_crc_hi;
      end else if (r_cur_last && !r_pid) begin
        w_from_hold = 1'b0;
        w_nb        = ~r_crc[7:0];
        w_more      = 1'b1;
        w_crc_start = 1'b1;
      end else
`endif
      if (r_cur_last) begin
        w_more = 1'b0;
      end else if (!r_hold_full) begin
        w_underrun = 1'b1;
      end
    end
  end

  assign w_tx_bit = w_stuff ? 1'b0 : (w_byte_end ? w_nb[0] : r_shift[0]);

`ifdef USB_LS_TX_CRC16_EN
  // CRC covers payload bits only: not SYNC, not the PID, not stuffed bits, not the CRC itself.
  assign w_crc_en   = w_bit_end && (r_state == DATA) && !w_stuff && !r_crc_phase &&
                      (w_byte_end ? (w_more && w_from_hold) : !r_pid);
  assign w_crc_fb   = r_crc[0] ^ w_tx_bit;
  assign w_crc_next = {1'b0, r_crc[15:1]} ^ (w_crc_fb ? 16'hA001 : 16'h0000);
`endif

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_pos        <= '0;
      r_ones       <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_hold_last  <= 1'b0;
      r_last_seen  <= 1'b0;
      r_cur_last   <= 1'b0;
      r_se0_second <= 1'b0;
      r_dp         <= 1'b0;
      r_dm         <= 1'b1;
      r_oe         <= 1'b0;
      r_busy       <= 1'b0;
      r_underrun   <= 1'b0;
`ifdef USB_LS_TX_CRC16_EN
      r_crc        <= 16'hFFFF;
      r_pid        <= 1'b0;
      r_crc_phase  <= 1'b0;
      r_crc_hi     <= 1'b0;
`endif
    end else begin
      r_underrun <= 1'b0;
      r_cnt      <= (w_bit_end || r_state == IDLE) ? '0 : r_cnt + CW'(1);

      case (r_state)
        IDLE: begin
          if (w_accept || r_hold_full) begin
            // First SYNC bit is a 0, so the line goes straight to K.
            r_state <= SYNC;
            r_oe    <= 1'b1;
            r_busy  <= 1'b1;
            r_dp    <= 1'b1;
            r_dm    <= 1'b0;
            r_shift <= 8'h40;
            r_pos   <= 3'd0;
            r_ones  <= 3'd0;
`ifdef USB_LS_TX_CRC16_EN
            r_crc       <= 16'hFFFF;
            r_crc_phase <= 1'b0;
            r_crc_hi    <= 1'b0;
`endif
          end
        end
        SYNC, DATA: begin
          if (w_bit_end) begin
            if (w_stuff || !w_byte_end || w_more) begin
              if (w_tx_bit) begin
                r_ones <= r_ones + 3'd1;
              end else begin
                r_ones <= 3'd0;
                r_dp   <= ~r_dp;
                r_dm   <= ~r_dm;
              end
            end
            if (w_stuff) begin
              r_ones <= 3'd0;
            end else if (!w_byte_end) begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_pos   <= r_pos + 3'd1;
            end else if (w_more) begin
              r_shift <= {1'b0, w_nb[7:1]};
              r_pos   <= 3'd0;
              r_state <= DATA;
              if (w_from_hold) begin
                r_hold_full <= 1'b0;
                r_cur_last  <= r_hold_last;
`ifdef USB_LS_TX_CRC16_EN
                r_pid       <= (r_state == SYNC);
`endif
              end
`ifdef USB_LS_TX_CRC16_EN
              if (w_crc_start) r_crc_phase <= 1'b1;
              if (r_crc_phase) r_crc_hi <= 1'b1;
`endif
            end else begin
              r_state      <= EOP_SE0;
              r_dp         <= 1'b0;
              r_dm         <= 1'b0;
              r_se0_second <= 1'b0;
              r_underrun   <= w_underrun;
            end
`ifdef USB_LS_TX_CRC16_EN
            if (w_crc_en) r_crc <= w_crc_next;
`endif
          end
        end
        EOP_SE0: begin
          if (w_bit_end) begin
            if (r_se0_second) begin
              r_state <= EOP_J;
              r_dp    <= 1'b0;
              r_dm    <= 1'b1;
            end else begin
              r_se0_second <= 1'b1;
            end
          end
        end
        EOP_J: begin
          if (w_bit_end) begin
            r_state     <= IDLE;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            // A byte caught during a truncated packet's EOP belongs to the next packet.
            r_last_seen <= r_hold_full && r_hold_last;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
        r_hold_last <= tx_last;
        if (tx_last) r_last_seen <= 1'b1;
      end
    end
  end

endmodule
